// File: rtl/iob_ila_dma_packer_pkg.sv
// Shared definitions for the ILA DMA packer.
// Contents:
//   - state_t: FSM state encoding.
//   - Header word field offsets.
//   - eff_len(): clamps the programmed burst length to the range 1..depth.
package iob_ila_dma_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_HDR  = 2'd3
  } state_t;

  localparam int unsigned HDR_LEN_LSB = 0;
  localparam int unsigned HDR_SEQ_LSB = 16;
  localparam int unsigned HDR_FIELD_W = 16;

  function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth);
    if (len == 0) return 1;
    if (len > depth) return depth;
    return len;
  endfunction

endpackage

// File: rtl/iob_ila_dma_fifo.sv
// Synchronous FIFO used by the ILA DMA packer.
// Ports:
//   clk_i, arst_i  clock and asynchronous active-high reset
//   cke_i          clock enable; all state holds while low
//   clear_i        synchronous clear of the pointers and level
//   push_i, data_i write one word (the caller guarantees the FIFO is not full)
//   pop_i          drop the head word (the caller guarantees the FIFO is not empty)
//   head_o         head word, read from the registered storage
//   level_o        occupancy, 0..2**FIFO_ADDR_W
module iob_ila_dma_fifo #(
  parameter int DMA_TDATA_W = 64,
  parameter int FIFO_ADDR_W = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   cke_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [DMA_TDATA_W-1:0] data_i,
  input  logic                   pop_i,
  output logic [DMA_TDATA_W-1:0] head_o,
  output logic [FIFO_ADDR_W:0]   level_o
);

  logic [DMA_TDATA_W-1:0] mem [2**FIFO_ADDR_W];
  logic [FIFO_ADDR_W-1:0] wr_ptr;
  logic [FIFO_ADDR_W-1:0] rd_ptr;
  logic [FIFO_ADDR_W:0]   level;

  always_ff @(posedge clk_i) begin
    if (cke_i && push_i && !clear_i) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (cke_i) begin
      if (clear_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_i) wr_ptr <= wr_ptr + 1'b1;
        if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
        case ({push_i, pop_i})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  assign head_o  = mem[rd_ptr];
  assign level_o = level;

endmodule

// File: rtl/iob_ila_dma_packer.sv
// ILA DMA packer: buffers the ILA sample stream and re-emits it as
// tlast-delimited AXI-Stream bursts of a programmable length.
// Ports:
//   clk_i, arst_i        clock and asynchronous active-high reset
//   cke_i                clock enable; all state holds while low
//   enable_i             low forces IDLE and empties the FIFO
//   burst_len_i          words per burst (clamped to 1..D), sampled at burst start
//   flush_i              pulse: send the buffered partial burst (honoured in WAIT only)
//   tdata_i/tvalid_i/tready_o        input stream
//   m_tdata_o/m_tvalid_o/m_tready_i/m_tlast_o  output stream
//   level_o              FIFO occupancy
//   busy_o               a burst (header or data) is in progress
// Build option: define IOB_ILA_DMA_PACKER_HEADER_EN to prefix each burst with
// a header word {seq[15:0], count[15:0]}.
module iob_ila_dma_packer
  import iob_ila_dma_packer_pkg::*;
#(
  parameter int DMA_TDATA_W = 64,
  parameter int FIFO_ADDR_W = 4,
  parameter int BURST_W     = 8
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   cke_i,
  input  logic                   enable_i,
  input  logic [BURST_W-1:0]     burst_len_i,
  input  logic                   flush_i,
  input  logic [DMA_TDATA_W-1:0] tdata_i,
  input  logic                   tvalid_i,
  output logic                   tready_o,
  output logic [DMA_TDATA_W-1:0] m_tdata_o,
  output logic                   m_tvalid_o,
  input  logic                   m_tready_i,
  output logic                   m_tlast_o,
  output logic [FIFO_ADDR_W:0]   level_o,
  output logic                   busy_o
);

  localparam int unsigned DEPTH = 2**FIFO_ADDR_W;
  localparam int          LW    = FIFO_ADDR_W + 1;

`ifdef IOB_ILA_DMA_PACKER_HEADER_EN
  localparam state_t BURST_FIRST = ST_HDR;
`else
  localparam state_t BURST_FIRST = ST_SEND;
`endif

  state_t                 state;
  state_t                 state_nxt;
  logic [LW-1:0]          remaining;
  logic [LW-1:0]          remaining_nxt;
  logic [LW-1:0]          level;
  logic [LW-1:0]          len_eff;
  logic [DMA_TDATA_W-1:0] head;
  logic                   push;
  logic                   pop;

  assign len_eff  = LW'(eff_len(32'(burst_len_i), DEPTH));
  assign tready_o = enable_i && (state != ST_IDLE) && (level != LW'(DEPTH));
  assign push     = tvalid_i && tready_o;
  assign pop      = (state == ST_SEND) && m_tready_i;
  assign level_o  = level;
  assign busy_o   = (state == ST_SEND) || (state == ST_HDR);

  iob_ila_dma_fifo #(
    .DMA_TDATA_W(DMA_TDATA_W),
    .FIFO_ADDR_W(FIFO_ADDR_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .clear_i(!enable_i),
    .push_i (push),
    .data_i (tdata_i),
    .pop_i  (pop),
    .head_o (head),
    .level_o(level)
  );

`ifdef IOB_ILA_DMA_PACKER_HEADER_EN
  logic [HDR_FIELD_W-1:0] seq;
  logic                   seq_inc;
`endif

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    m_tvalid_o    = 1'b0;
    m_tlast_o     = 1'b0;
    m_tdata_o     = '0;
`ifdef IOB_ILA_DMA_PACKER_HEADER_EN
    seq_inc       = 1'b0;
`endif
    case (state)
      ST_IDLE: if (enable_i) state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A full burst wins over a flush arriving in the same cycle.
        if (level >= len_eff) begin
          remaining_nxt = len_eff;
          state_nxt     = BURST_FIRST;
        end else if (flush_i && (level != '0)) begin
          remaining_nxt = level;
          state_nxt     = BURST_FIRST;
        end
      end
      ST_SEND: begin
        m_tvalid_o = 1'b1;
        m_tdata_o  = head;
        m_tlast_o  = (remaining == LW'(1));
        if (m_tready_i) begin
          remaining_nxt = remaining - 1'b1;
          if (remaining == LW'(1)) begin
            state_nxt = ST_WAIT;
`ifdef IOB_ILA_DMA_PACKER_HEADER_EN
            seq_inc   = 1'b1;
`endif
          end
        end
      end
`ifdef IOB_ILA_DMA_PACKER_HEADER_EN
      ST_HDR: begin
        m_tvalid_o = 1'b1;
        m_tdata_o[HDR_SEQ_LSB +: HDR_FIELD_W] = seq;
        m_tdata_o[HDR_LEN_LSB +: HDR_FIELD_W] = HDR_FIELD_W'(remaining);
        if (m_tready_i) state_nxt = ST_SEND;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable_i) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else if (cke_i) begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

`ifdef IOB_ILA_DMA_PACKER_HEADER_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      seq <= '0;
    end else if (cke_i) begin
      if (!enable_i)    seq <= '0;
      else if (seq_inc) seq <= seq + 1'b1;
    end
  end
`endif

endmodule
